// File: rtl/imem_boot_loader.sv
// Boot loader: holds the CPU in reset, streams bytes into instruction memory,
// then releases the CPU after a fixed hold window.
module imem_boot_loader #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   loaded_count
);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

    localparam int HCW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [ADDR_W:0] MAX_LEN   = (ADDR_W + 1)'(1) << ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD_CYCLES);
    localparam logic [HCW-1:0]  HOLD_ONE  = HCW'(1);

    state_t              r_state;
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W:0]     r_cnt;
    logic [HCW-1:0]      r_hold;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_cpu_rst;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic                w_legal;
    logic [ADDR_W:0]     w_cnt_nxt;

    assign w_legal   = (load_len != '0) && (load_len <= MAX_LEN);
    assign w_cnt_nxt = r_cnt + CNT_ONE;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_len     <= '0;
            r_cnt     <= '0;
            r_hold    <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cpu_rst <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_we <= 1'b0;
            unique case (r_state)
                IDLE, RUN: begin
                    if (start) begin
                        if (w_legal) begin
                            r_state   <= LOAD;
                            r_len     <= load_len;
                            r_cnt     <= '0;
                            r_err     <= 1'b0;
                            r_cpu_rst <= 1'b1;
                            r_busy    <= 1'b1;
                            r_done    <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        r_we    <= 1'b1;
                        r_addr  <= r_cnt[ADDR_W-1:0];
                        r_wdata <= in_data;
                        r_cnt   <= w_cnt_nxt;
                        if (w_cnt_nxt == r_len) begin
                            r_state <= HOLD;
                            r_hold  <= '0;
                        end
                    end
                end
                HOLD: begin
                    // first HOLD cycle presents the last write, then HOLD_CYCLES more
                    if (r_hold == HOLD_LAST) begin
                        r_state   <= RUN;
                        r_cpu_rst <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_hold <= r_hold + HOLD_ONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready     = (r_state == LOAD);
    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign cpu_reset    = r_cpu_rst;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_err;
    assign loaded_count = r_cnt;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader against a cycle-level
// behavioural model of the load / hold / run sequence.
module tb_imem_boot_loader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int HOLD   = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_HOLD = 2;
    localparam int P_RUN  = 3;

    logic              clk;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   load_len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   loaded_count;

    imem_boot_loader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .load_len(load_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
        .loaded_count(loaded_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int m_phase = P_IDLE;
    int m_len   = 0;
    int m_cnt   = 0;
    int m_after = 0;
    bit m_err   = 1'b0;
    bit m_we;
    int m_addr;
    int m_data;
    int n_writes;
    int last_addr;

    logic [DATA_W-1:0] exp_mem [DEPTH];
    logic [DATA_W-1:0] dut_mem [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // One clock: advance the model on the current inputs, then compare.
    task automatic cyc();
        m_we = 1'b0;
        if (!reset) begin
            m_phase = P_IDLE;
            m_cnt   = 0;
            m_err   = 1'b0;
        end else if (m_phase == P_IDLE || m_phase == P_RUN) begin
            if (start) begin
                if (load_len >= 1 && int'(load_len) <= DEPTH) begin
                    m_phase = P_LOAD;
                    m_len   = int'(load_len);
                    m_cnt   = 0;
                    m_err   = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else if (m_phase == P_LOAD) begin
            if (in_valid) begin
                m_we   = 1'b1;
                m_addr = m_cnt;
                m_data = int'(in_data);
                exp_mem[m_cnt] = in_data;
                m_cnt++;
                if (m_cnt == m_len) begin
                    m_phase = P_HOLD;
                    m_after = 0;
                end
            end
        end else begin
            m_after++;
            if (m_after > HOLD) m_phase = P_RUN;
        end
        @(posedge clk);
        #1;
        chk("in_ready", in_ready, m_phase == P_LOAD);
        chk("imem_we", imem_we, m_we);
        chk("cpu_reset", cpu_reset, m_phase != P_RUN);
        chk("busy", busy, m_phase == P_LOAD || m_phase == P_HOLD);
        chk("done", done, m_phase == P_RUN);
        chk("error", error, m_err);
        chk("loaded_count", loaded_count, m_cnt);
        if (m_we) begin
            chk("imem_addr", imem_addr, m_addr);
            chk("imem_wdata", imem_wdata, m_data);
        end
        if (imem_we === 1'b1) begin
            dut_mem[imem_addr] = imem_wdata;
            last_addr = int'(imem_addr);
            n_writes++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_start(input int len);
        start    = 1'b1;
        load_len = (ADDR_W + 1)'(len);
        n_writes = 0;
        cyc();
        start = 1'b0;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input int gap);
        in_valid = 1'b0;
        repeat (gap) cyc();
        in_valid = 1'b1;
        in_data  = d;
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b1;
        load_len = 9'd3;
        in_valid = 1'b0;
        in_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_mem[i] = '0;
            dut_mem[i] = '0;
        end

        // reset wins over a simultaneous start
        idle(2);
        start = 1'b0;
        reset = 1'b1;
        idle(1);

        // basic back-to-back load of three bytes
        do_start(3);
        send(8'hA1, 0);
        send(8'hB2, 0);
        send(8'hC3, 0);
        chk("t1_ready_after_last", in_ready, 1'b0);
        idle(HOLD + 1);
        chk("t1_done", done, 1'b1);
        chk("t1_count", loaded_count, 3);
        chk("t1_writes", n_writes, 3);

        // gaps between valid bytes
        do_start(4);
        send(8'($urandom), 0);
        send(8'($urandom), 2);
        send(8'($urandom), 5);
        send(8'($urandom), 1);
        idle(3);
        chk("t2_writes", n_writes, 4);
        chk("t2_last_addr", last_addr, 3);
        idle(HOLD);

        // illegal length in IDLE, then a legal single-byte load
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        do_start(0);
        idle(2);
        chk("t3_err", error, 1'b1);
        chk("t3_no_write", n_writes, 0);
        do_start(1);
        chk("t3_err_clr", error, 1'b0);
        send(8'($urandom), 1);
        idle(HOLD + 1);
        chk("t3_done", done, 1'b1);

        // full-depth load, no wrap
        do_start(DEPTH);
        for (int i = 0; i < DEPTH; i++)
            send(8'($urandom), ($urandom_range(0, 3) == 0) ? 1 : 0);
        idle(HOLD + 1);
        chk("t4_writes", n_writes, DEPTH);
        chk("t4_last_addr", last_addr, DEPTH - 1);
        chk("t4_count", loaded_count, DEPTH);
        chk("t4_done", done, 1'b1);
        for (int i = 0; i < DEPTH; i++)
            chk("t4_mem", dut_mem[i], exp_mem[i]);

        // reset in the middle of a load
        do_start(5);
        send(8'($urandom), 0);
        send(8'($urandom), 0);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        chk("t5_count", loaded_count, 0);
        chk("t5_busy", busy, 1'b0);
        do_start(3);
        send(8'h5A, 0);
        chk("t5_restart_addr", last_addr, 0);
        send(8'($urandom), 2);
        send(8'($urandom), 0);
        idle(HOLD + 1);

        // illegal start in RUN, then a restart with a stray start in LOAD
        do_start(DEPTH + 44);
        chk("t6_err_run", error, 1'b1);
        chk("t6_still_run", done, 1'b1);
        do_start(2);
        chk("t6_cpu_rst", cpu_reset, 1'b1);
        chk("t6_done_low", done, 1'b0);
        start    = 1'b1;
        load_len = 9'd1;
        cyc();
        start = 1'b0;
        send(8'($urandom), 0);
        send(8'($urandom), 1);
        idle(HOLD + 1);
        chk("t6_writes", n_writes, 2);
        chk("t6_count", loaded_count, 2);
        chk("t6_done", done, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sequences processor bring-up: holds the CPU in reset, streams instruction bytes into instruction memory at consecutive addresses, then releases the CPU.
- Sits between a byte source (UART/debug/bench) and topLevel's instruction-memory write port and CPU reset.
- Replaces hand-driven flashEn/flashInstruction toggling with a valid/ready handshake and a counted load.

Parameters:
- ADDR_W, 8, instruction memory address width; depth = 2^ADDR_W bytes.
- DATA_W, 8, instruction byte width.
- HOLD_CYCLES, 4, cycles the CPU reset stays asserted after the last write (min 1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low; sampled only on the rising edge of clk.
- start  in  1  single-cycle request to begin a load.
- load_len  in  ADDR_W+1  number of bytes to load; legal range 1..2^ADDR_W; sampled with start.
- in_valid  in  1  source has a byte on in_data.
- in_data  in  DATA_W  instruction byte.
- in_ready  out  1  loader accepts a byte; equals (state==LOAD).
- imem_we  out  1  instruction memory write enable (flashEn equivalent).
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  DATA_W  write data (flashInstruction equivalent).
- cpu_reset  out  1  active-high CPU reset.
- busy  out  1  high in LOAD and HOLD.
- done  out  1  high in RUN.
- error  out  1  sticky: illegal load_len on start.
- loaded_count  out  ADDR_W+1  bytes written in the current or last load.

Behaviour:
- Reset (reset==0 at an edge): state IDLE; imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, busy=0, done=0, error=0, loaded_count=0. in_ready=0.
- States: IDLE, LOAD, HOLD, RUN. All outputs except in_ready are registered.
- IDLE: cpu_reset=1.
  - start with load_len in 1..2^ADDR_W: latch length, clear count and error, go to LOAD.
  - start with load_len==0 or load_len>2^ADDR_W: set error=1, stay in IDLE, no writes.
- LOAD:
  - A handshake is in_valid&&in_ready at an edge.
  - On a handshake, the next cycle drives imem_we=1, imem_addr=loaded_count(old), imem_wdata=in_data; loaded_count increments. Latency: 1 cycle.
  - imem_we is 0 in any cycle not following a handshake. Back-to-back handshakes give one write per cycle.
  - The handshake that makes loaded_count==length moves the FSM to HOLD, so in_ready is 0 in the cycle the last write is presented.
  - start is ignored in LOAD.
- HOLD: cpu_reset=1 for exactly HOLD_CYCLES cycles, counted from the cycle after the last imem_we. Then go to RUN.
- RUN: cpu_reset=0, done=1, busy=0.
  - start with a legal load_len: next cycle cpu_reset=1, done=0, go to LOAD with address restarting at 0.
  - start with an illegal load_len in RUN: set error=1, stay in RUN.
- Addressing: no wrap. With length 2^ADDR_W the last address is 2^ADDR_W-1, and loaded_count reaches 2^ADDR_W (hence its ADDR_W+1 width).
- Reset mid-load or mid-hold: all outputs return to reset values on the next edge. Memory contents already written are not cleared.
- Simultaneous reset and start: reset wins.

Test Plan:
- Reset low 2 cycles, then start with load_len=3; stream A1,B2,C3 back-to-back -> writes (0,A1),(1,B2),(2,C3) on consecutive cycles, each 1 cycle after its handshake; in_ready=0 after the 3rd handshake; cpu_reset=1 for 4 cycles after the last write, then 0; done=1; loaded_count=3.
- load_len=4 with in_valid gaps of 0, 2 and 5 cycles -> exactly 4 writes at addresses 0..3, no write in idle cycles, no duplicated data.
- start with load_len=0 -> error=1, no imem_we, cpu_reset stays 1; then start with load_len=1 -> error clears and a normal load completes.
- load_len=256 -> 256 writes at addresses 0x00..0xFF, no wrap to 0; loaded_count=256; done asserts after HOLD.
- load_len=5, reset driven low after 2 handshakes -> next edge: imem_we=0, cpu_reset=1, busy=0, loaded_count=0; a new start writes from address 0.
- In RUN, start with load_len=2 -> cpu_reset=1 and done=0 the next cycle, writes restart at address 0; a start pulse during that LOAD has no effect.
